// File: rtl/sorting_pkg.sv
// -----------------------------------------------------------------------------
// sorting_pkg
// Shared definitions for the sorting network and the readers attached to it.
//   NUM_LANES / NETWORK_WIDTH / INDEX_WIDTH / RANK_WIDTH : geometry
//   lane_t   : one network lane (value plus original index)
//   state_t  : reader FSM states
//   latch_count() : maps a requested read count onto 1..NUM_LANES
// -----------------------------------------------------------------------------
package sorting_pkg;

  localparam int NUM_LANES     = 8;
  localparam int NETWORK_WIDTH = 16;
  localparam int INDEX_WIDTH   = $clog2(NUM_LANES);
  localparam int RANK_WIDTH    = $clog2(NUM_LANES) + 1;

  typedef struct packed {
    logic [NETWORK_WIDTH-1:0] value;
    logic [INDEX_WIDTH-1:0]   index;
  } lane_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Zero or an over-range request means "the whole frame".
  function automatic logic [RANK_WIDTH-1:0] latch_count(input logic [RANK_WIDTH-1:0] rc);
    logic [RANK_WIDTH-1:0] cnt;
    if (rc == '0 || rc > RANK_WIDTH'(NUM_LANES)) cnt = RANK_WIDTH'(NUM_LANES);
    else                                         cnt = rc;
    return cnt;
  endfunction

endpackage

// File: rtl/sorted_lane_serializer_if.sv
// -----------------------------------------------------------------------------
// sorted_lane_serializer_if
// Frame-in / beat-out bundle for sorted_lane_serializer.
//   slave  : serializer view (accepts frames, emits beats)
//   master : environment view (presents frames, consumes beats)
// Optional signals threshold / frame_dropped exist only when
// SORTED_LANE_SERIALIZER_THRESHOLD_EN is defined.
//
// Handshake: both channels are strict valid/ready. A transfer happens on a
// rising clk edge where valid && ready. The sender keeps valid and its payload
// stable until that edge; valid never depends on ready. in_ready may depend
// combinationally on out_ready (zero-bubble frame turnover).
// -----------------------------------------------------------------------------
interface sorted_lane_serializer_if;
  import sorting_pkg::*;

  logic                               in_valid;
  logic                               in_ready;
  logic [NUM_LANES*NETWORK_WIDTH-1:0] in_values;
  logic [NUM_LANES*INDEX_WIDTH-1:0]   in_indices;
  logic [RANK_WIDTH-1:0]              read_count;
  logic                               read_descending;
  logic                               out_valid;
  logic                               out_ready;
  logic [NETWORK_WIDTH-1:0]           out_value;
  logic [INDEX_WIDTH-1:0]             out_index;
  logic [RANK_WIDTH-1:0]              out_rank;
  logic                               out_last;
`ifdef SORTED_LANE_SERIALIZER_THRESHOLD_EN
  logic [NETWORK_WIDTH-1:0]           threshold;
  logic                               frame_dropped;

  modport slave (
    input  in_valid, in_values, in_indices, read_count, read_descending, out_ready, threshold,
    output in_ready, out_valid, out_value, out_index, out_rank, out_last, frame_dropped
  );
  modport master (
    output in_valid, in_values, in_indices, read_count, read_descending, out_ready, threshold,
    input  in_ready, out_valid, out_value, out_index, out_rank, out_last, frame_dropped
  );
`else
  modport slave (
    input  in_valid, in_values, in_indices, read_count, read_descending, out_ready,
    output in_ready, out_valid, out_value, out_index, out_rank, out_last
  );
  modport master (
    output in_valid, in_values, in_indices, read_count, read_descending, out_ready,
    input  in_ready, out_valid, out_value, out_index, out_rank, out_last
  );
`endif

endinterface

// File: rtl/sorted_lane_select.sv
// -----------------------------------------------------------------------------
// sorted_lane_select
// Combinational lane picker for readers of the sorting network.
//   lanes      : lane array, lane 0 smallest
//   pos        : position in read order
//   descending : 1 = position 0 is the largest lane
//   lane       : selected lane
// -----------------------------------------------------------------------------
module sorted_lane_select
  import sorting_pkg::*;
(
  input  lane_t                  lanes [NUM_LANES],
  input  logic [INDEX_WIDTH-1:0] pos,
  input  logic                   descending,
  output lane_t                  lane
);

  logic [INDEX_WIDTH-1:0] sel;

  always_comb begin
    sel  = descending ? (INDEX_WIDTH'(NUM_LANES - 1) - pos) : pos;
    lane = lanes[sel];
  end

endmodule

// File: rtl/sorted_lane_serializer.sv
// -----------------------------------------------------------------------------
// sorted_lane_serializer
// Captures one sorted frame of NUM_LANES lanes in a single handshake and
// streams the selected top entries out one per beat.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : sorted_lane_serializer_if.slave (frame in, beats out)
//   dbg_state  : current FSM state
// Optional build macro SORTED_LANE_SERIALIZER_THRESHOLD_EN adds a value
// threshold sampled at capture and a one-cycle frame_dropped pulse when no
// lane qualifies.
// -----------------------------------------------------------------------------
module sorted_lane_serializer
  import sorting_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  sorted_lane_serializer_if.slave  bus,
  output state_t                   dbg_state
);

  state_t                 state;
  lane_t                  lanes_q  [NUM_LANES];
  lane_t                  in_lanes [NUM_LANES];
  logic [RANK_WIDTH-1:0]  count_q;
  logic                   desc_q;
  logic [INDEX_WIDTH-1:0] offset_q;   // first lane read in ascending order

  logic                   capture;
  logic                   cap_empty;
  logic [RANK_WIDTH-1:0]  cap_count;
  logic [INDEX_WIDTH-1:0] cap_offset;
  logic [RANK_WIDTH-1:0]  rank_nxt;
  logic [INDEX_WIDTH-1:0] nxt_pos;
  lane_t                  cap_lane;
  lane_t                  nxt_lane;

  assign dbg_state = state;

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      in_lanes[k].value = bus.in_values[k*NETWORK_WIDTH +: NETWORK_WIDTH];
      in_lanes[k].index = bus.in_indices[k*INDEX_WIDTH +: INDEX_WIDTH];
    end
  end

  // A new frame is taken either when idle or on the very cycle the last beat
  // leaves, so consecutive frames stream without a gap.
  assign bus.in_ready = !rst && ((state == IDLE) ||
                                 (state == STREAM && bus.out_last && bus.out_ready));
  assign capture  = bus.in_valid && bus.in_ready;
  assign rank_nxt = bus.out_rank + RANK_WIDTH'(1);
  assign nxt_pos  = offset_q + rank_nxt[INDEX_WIDTH-1:0];

`ifdef SORTED_LANE_SERIALIZER_THRESHOLD_EN
  logic [RANK_WIDTH-1:0] qual_count;
  logic [RANK_WIDTH-1:0] base_count;

  // Lanes are sorted, so qualifying lanes are the top qual_count lanes:
  // a prefix when descending, a tail starting at NUM_LANES-qual_count when
  // ascending.
  always_comb begin
    qual_count = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (in_lanes[k].value >= bus.threshold) qual_count = qual_count + RANK_WIDTH'(1);
    end
    base_count = latch_count(bus.read_count);
    cap_count  = (qual_count < base_count) ? qual_count : base_count;
    cap_offset = bus.read_descending ? '0
                                     : INDEX_WIDTH'(RANK_WIDTH'(NUM_LANES) - qual_count);
  end
`else
  always_comb begin
    cap_count  = latch_count(bus.read_count);
    cap_offset = '0;
  end
`endif

  assign cap_empty = (cap_count == '0);

  sorted_lane_select u_cap_sel (
    .lanes      (in_lanes),
    .pos        (cap_offset),
    .descending (bus.read_descending),
    .lane       (cap_lane)
  );

  sorted_lane_select u_nxt_sel (
    .lanes      (lanes_q),
    .pos        (nxt_pos),
    .descending (desc_q),
    .lane       (nxt_lane)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count_q       <= '0;
      desc_q        <= 1'b0;
      offset_q      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_value <= '0;
      bus.out_index <= '0;
      bus.out_rank  <= '0;
      for (int k = 0; k < NUM_LANES; k++) lanes_q[k] <= '0;
`ifdef SORTED_LANE_SERIALIZER_THRESHOLD_EN
      bus.frame_dropped <= 1'b0;
`endif
    end else begin
`ifdef SORTED_LANE_SERIALIZER_THRESHOLD_EN
      bus.frame_dropped <= capture && cap_empty;
`endif
      if (capture) begin
        for (int k = 0; k < NUM_LANES; k++) lanes_q[k] <= in_lanes[k];
        count_q       <= cap_count;
        desc_q        <= bus.read_descending;
        offset_q      <= cap_offset;
        bus.out_rank  <= '0;
        bus.out_value <= cap_lane.value;
        bus.out_index <= cap_lane.index;
        if (cap_empty) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.out_last  <= 1'b0;
        end else begin
          state         <= STREAM;
          bus.out_valid <= 1'b1;
          bus.out_last  <= (cap_count == RANK_WIDTH'(1));
        end
      end else if (state == STREAM && bus.out_ready) begin
        if (bus.out_last) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.out_last  <= 1'b0;
        end else begin
          bus.out_rank  <= rank_nxt;
          bus.out_value <= nxt_lane.value;
          bus.out_index <= nxt_lane.index;
          bus.out_last  <= (rank_nxt == count_q - RANK_WIDTH'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_sorted_lane_serializer.sv
// -----------------------------------------------------------------------------
// tb_sorted_lane_serializer
// Directed bench for sorted_lane_serializer: a table of frames with their
// hand-computed beat sequences, plus sequences for reset, back-to-back frames
// and (when SORTED_LANE_SERIALIZER_THRESHOLD_EN is defined) threshold drops.
// -----------------------------------------------------------------------------
module tb_sorted_lane_serializer;
  import sorting_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;

  always #5 clk = ~clk;

  sorted_lane_serializer_if dif ();

  sorted_lane_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (dif),
    .dbg_state (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- vectors ----------------
  typedef struct packed {
    logic [7:0][15:0] values;   // [k] = lane k
    logic [7:0][2:0]  indices;
    logic [3:0]       rc;
    logic             desc;
    logic [15:0]      thr;
    logic             stall;
    logic [3:0]       n;        // expected beat count
    logic [0:7][15:0] ev;       // expected values, beat 0 first
    logic [0:7][2:0]  ei;       // expected indices, beat 0 first
  } vec_t;

  // Lane literals are written lane 7 first.
  localparam logic [7:0][15:0] BASE_V = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [7:0][2:0]  BASE_I = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [7:0][15:0] F2_V   = {16'hFFFF, 16'h1000, 16'h0300, 16'h0200,
                                         16'h0100, 16'h0010, 16'h0010, 16'h0005};
  localparam logic [7:0][2:0]  F2_I   = {3'd4, 3'd5, 3'd2, 3'd7, 3'd1, 3'd6, 3'd0, 3'd3};

  vec_t vecs[$];

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];   // {value, index, rank, last}
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkvec(input logic [7:0][15:0] v, input logic [7:0][2:0] i,
                                 input logic [3:0] rc, input logic desc, input logic [15:0] thr,
                                 input logic stall, input logic [3:0] n,
                                 input logic [0:7][15:0] ev, input logic [0:7][2:0] ei);
    vec_t r;
    r.values = v;  r.indices = i; r.rc = rc; r.desc = desc; r.thr = thr;
    r.stall = stall; r.n = n; r.ev = ev; r.ei = ei;
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_frame(input vec_t v);
    dif.in_values       = v.values;
    dif.in_indices      = v.indices;
    dif.read_count      = v.rc;
    dif.read_descending = v.desc;
`ifdef SORTED_LANE_SERIALIZER_THRESHOLD_EN
    dif.threshold       = v.thr;
`endif
  endtask

  // Called just after a falling edge; returns on the falling edge after capture.
  task automatic send_frame(input vec_t v);
    int cyc = 0;
    bit acc = 1'b0;
    drive_frame(v);
    dif.in_valid = 1'b1;
    while (!acc && cyc < 32) begin
      #1 acc = dif.in_ready;
      @(negedge clk);
      cyc++;
    end
    dif.in_valid = 1'b0;
    if (!acc) chk("capture_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_expected(input vec_t v);
    for (int r = 0; r < int'(v.n); r++)
      exp_q.push_back({v.ev[r], v.ei[r], 4'(r), (r == int'(v.n) - 1)});
  endtask

  // Consumes beats until the expected queue drains; stall gives ready 1,0,0,1.
  task automatic collect(input bit stall);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 64) begin
      dif.out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      chk("beat_valid", 32'(dif.out_valid), 32'd1);
      if (dif.out_valid) begin
        chk("beat", {8'd0, dif.out_value, dif.out_index, dif.out_rank, dif.out_last}, {8'd0, exp_q[0]});
        if (dif.out_ready) void'(exp_q.pop_front());
      end
      cyc++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      chk("collect_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    dif.out_ready = 1'b1;
  endtask

  task automatic check_idle();
    #1;
    chk("idle_out_valid", 32'(dif.out_valid), 32'd0);
    chk("idle_in_ready", 32'(dif.in_ready), 32'd1);
  endtask

  task automatic apply_vec(input vec_t v);
    push_expected(v);
    send_frame(v);
    collect(v.stall);
    check_idle();
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t a, b;

    vecs.push_back(mkvec(BASE_V, BASE_I, 4'd0, 1'b1, 16'd0, 1'b0, 4'd8,
      {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
      {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}));
    vecs.push_back(mkvec(BASE_V, BASE_I, 4'd3, 1'b0, 16'd0, 1'b0, 4'd3,
      {16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
      {3'd7, 3'd6, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}));
    vecs.push_back(mkvec(F2_V, F2_I, 4'd9, 1'b0, 16'd0, 1'b0, 4'd8,
      {16'h0005, 16'h0010, 16'h0010, 16'h0100, 16'h0200, 16'h0300, 16'h1000, 16'hFFFF},
      {3'd3, 3'd0, 3'd6, 3'd1, 3'd7, 3'd2, 3'd5, 3'd4}));
    vecs.push_back(mkvec(F2_V, F2_I, 4'd1, 1'b1, 16'd0, 1'b0, 4'd1,
      {16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
      {3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}));
    vecs.push_back(mkvec(F2_V, F2_I, 4'd4, 1'b1, 16'd0, 1'b1, 4'd4,
      {16'hFFFF, 16'h1000, 16'h0300, 16'h0200, 16'd0, 16'd0, 16'd0, 16'd0},
      {3'd4, 3'd5, 3'd2, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0}));
`ifdef SORTED_LANE_SERIALIZER_THRESHOLD_EN
    vecs.push_back(mkvec(BASE_V, BASE_I, 4'd0, 1'b1, 16'd6, 1'b0, 4'd3,
      {16'd8, 16'd7, 16'd6, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
      {3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}));
    vecs.push_back(mkvec(BASE_V, BASE_I, 4'd2, 1'b0, 16'd6, 1'b0, 4'd2,
      {16'd6, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
      {3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}));
`endif

    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    drive_frame(vecs[0]);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(dif.in_ready), 32'd0);
    chk("rst_outputs", {dif.out_valid, dif.out_last, dif.out_value, dif.out_index, dif.out_rank},
        32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", 32'(dif.in_ready), 32'd1);
    chk("post_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);

    // Table
    foreach (vecs[i]) apply_vec(vecs[i]);

    // Back-to-back: B offered while A's last beat is accepted
    a = mkvec(BASE_V, BASE_I, 4'd2, 1'b0, 16'd0, 1'b0, 4'd0, '0, '0);
    b = mkvec(F2_V, F2_I, 4'd2, 1'b1, 16'd0, 1'b0, 4'd2,
      {16'hFFFF, 16'h1000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
      {3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0});
    send_frame(a);
    #1 chk("b2b_a0", {dif.out_value, dif.out_index, dif.out_rank, dif.out_last}, {16'd1, 3'd7, 4'd0, 1'b0});
    @(negedge clk);
    drive_frame(b);
    dif.in_valid = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(dif.in_ready), 32'd1);
    chk("b2b_a1", {dif.out_value, dif.out_index, dif.out_rank, dif.out_last}, {16'd2, 3'd6, 4'd1, 1'b1});
    @(negedge clk);
    dif.in_valid = 1'b0;
    push_expected(b);
    collect(1'b0);
    check_idle();

    // Reset mid-frame at rank 2 of 8
    send_frame(vecs[0]);
    repeat (2) @(negedge clk);
    #1 chk("mid_rank2", {dif.out_value, dif.out_index, dif.out_rank, dif.out_last}, {16'd6, 3'd2, 4'd2, 1'b0});
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(dif.out_valid), 32'd0);
    chk("mid_rst_out_last", 32'(dif.out_last), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("mid_rst_in_ready", 32'(dif.in_ready), 32'd1);
    chk("mid_rst_out_valid2", 32'(dif.out_valid), 32'd0);
    apply_vec(vecs[0]);

`ifdef SORTED_LANE_SERIALIZER_THRESHOLD_EN
    // Nothing qualifies: no beats, one-cycle drop pulse
    a = mkvec(BASE_V, BASE_I, 4'd0, 1'b1, 16'd9, 1'b0, 4'd0, '0, '0);
    send_frame(a);
    #1;
    chk("drop_pulse", 32'(dif.frame_dropped), 32'd1);
    chk("drop_out_valid", 32'(dif.out_valid), 32'd0);
    chk("drop_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    #1;
    chk("drop_pulse_end", 32'(dif.frame_dropped), 32'd0);
    chk("drop_out_valid2", 32'(dif.out_valid), 32'd0);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
